// File: rtl/nios_base_sysid_pkg.sv
// Shared constants for the sysid checker: FSM state codes,
// sysid word addresses and the data width.
package nios_base_sysid_pkg;

   localparam int SYSID_DATA_W = 32;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RD_ID = 3'd1;
   localparam logic [2:0] ST_WT_ID = 3'd2;
   localparam logic [2:0] ST_RD_TS = 3'd3;
   localparam logic [2:0] ST_WT_TS = 3'd4;
   localparam logic [2:0] ST_CHECK = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

endpackage

// File: rtl/nios_base_sysid_timeout.sv
// Per-transaction cycle counter with synchronous clear.
// Ports: clock, reset_n, clr_i, en_i in; expire_o out.
module nios_base_sysid_timeout #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Saturates at LAST: an expiry is acted on the same
   // cycle, so the count never needs to go further.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && cnt_q != LAST)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // High during the LIMIT-th counted cycle of a transaction.
   assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/nios_base_sysid_checker.sv
// Avalon-MM read master that fetches sysid ID/timestamp and checks them.
// Ports: clock/reset_n, m_* read master, recheck in; done/pass/err_*/sys_*/retries_used out.
module nios_base_sysid_checker
   import nios_base_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd953745243,
   parameter logic [31:0] EXPECTED_TS    = 32'd1314387359,
   parameter int unsigned READ_LATENCY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   output logic                    m_address,
   output logic                    m_read,
   input  logic                    m_waitrequest,
   input  logic [SYSID_DATA_W-1:0] m_readdata,
   input  logic                    recheck,
   output logic                    done,
   output logic                    pass,
   output logic                    err_id,
   output logic                    err_ts,
   output logic                    err_timeout,
   output logic [SYSID_DATA_W-1:0] sys_id,
   output logic [SYSID_DATA_W-1:0] sys_ts,
   output logic [2:0]              retries_used
);

   localparam bit HAS_WT = (READ_LATENCY != 0);
   localparam logic [1:0] LAT_LAST =
      2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
   localparam logic [2:0] RET_MAX = 3'(MAX_RETRIES);

   logic [2:0]  state_q, state_d;
   logic        m_read_q, m_read_d;
   logic        m_addr_q, m_addr_d;
   logic [1:0]  lat_q, lat_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        err_id_q, err_id_d;
   logic        err_ts_q, err_ts_d;
   logic        err_to_q, err_to_d;
   logic [31:0] sys_id_q, sys_id_d;
   logic [31:0] sys_ts_q, sys_ts_d;
   logic [2:0]  ret_q, ret_d;

   logic in_rd, in_wt, accept, cap_wt;
   logic progress, expire, tmo, enter_rd;

   assign in_rd  = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
   assign in_wt  = (state_q == ST_WT_ID) || (state_q == ST_WT_TS);
   assign accept = m_read_q && !m_waitrequest;
   assign cap_wt = in_wt && (lat_q == LAT_LAST);

   // Forward progress on the final budgeted cycle beats expiry.
   assign progress = (in_rd && accept) || cap_wt;
   assign tmo      = expire && !progress;

   nios_base_sysid_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_tmo (
      .clock    (clock),
      .reset_n  (reset_n),
      .clr_i    (enter_rd),
      .en_i     (in_rd || in_wt),
      .expire_o (expire)
   );

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_id_d = err_id_q;
      err_ts_d = err_ts_q;
      err_to_d = err_to_q;
      sys_id_d = sys_id_q;
      sys_ts_d = sys_ts_q;
      ret_d    = ret_q;
      enter_rd = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (recheck || (state_q == ST_IDLE && AUTO_START)) begin
               state_d  = ST_RD_ID;
               enter_rd = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               err_id_d = 1'b0;
               err_ts_d = 1'b0;
               err_to_d = 1'b0;
               ret_d    = '0;
            end
         end
         ST_RD_ID: begin
            if (accept) begin
               if (HAS_WT) begin
                  state_d = ST_WT_ID;
                  lat_d   = '0;
               end else begin
                  sys_id_d = m_readdata;
                  state_d  = ST_RD_TS;
                  enter_rd = 1'b1;
               end
            end
         end
         ST_WT_ID: begin
            if (cap_wt) begin
               sys_id_d = m_readdata;
               state_d  = ST_RD_TS;
               enter_rd = 1'b1;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_RD_TS: begin
            if (accept) begin
               if (HAS_WT) begin
                  state_d = ST_WT_TS;
                  lat_d   = '0;
               end else begin
                  sys_ts_d = m_readdata;
                  state_d  = ST_CHECK;
               end
            end
         end
         ST_WT_TS: begin
            if (cap_wt) begin
               sys_ts_d = m_readdata;
               state_d  = ST_CHECK;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_CHECK: begin
            err_id_d = (sys_id_q != EXPECTED_ID);
            err_ts_d = (sys_ts_q != EXPECTED_TS);
            pass_d   = (sys_id_q == EXPECTED_ID) &&
                       (sys_ts_q == EXPECTED_TS) && !err_to_q;
            done_d   = 1'b1;
            state_d  = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A timeout always restarts from word 0 so both words
      // come from the same successful pass.
      if (tmo) begin
         if (ret_q < RET_MAX) begin
            ret_d    = ret_q + 1'b1;
            state_d  = ST_RD_ID;
            enter_rd = 1'b1;
         end else begin
            err_to_d = 1'b1;
            done_d   = 1'b1;
            pass_d   = 1'b0;
            state_d  = ST_DONE;
         end
      end

      m_read_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
      m_addr_d = (state_d == ST_RD_TS) ? SYSID_ADDR_TS
                                       : SYSID_ADDR_ID;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         m_read_q <= 1'b0;
         m_addr_q <= 1'b0;
         lat_q    <= '0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_id_q <= 1'b0;
         err_ts_q <= 1'b0;
         err_to_q <= 1'b0;
         sys_id_q <= '0;
         sys_ts_q <= '0;
         ret_q    <= '0;
      end else begin
         state_q  <= state_d;
         m_read_q <= m_read_d;
         m_addr_q <= m_addr_d;
         lat_q    <= lat_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_id_q <= err_id_d;
         err_ts_q <= err_ts_d;
         err_to_q <= err_to_d;
         sys_id_q <= sys_id_d;
         sys_ts_q <= sys_ts_d;
         ret_q    <= ret_d;
      end
   end

   assign m_read       = m_read_q;
   assign m_address    = m_addr_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_id       = err_id_q;
   assign err_ts       = err_ts_q;
   assign err_timeout  = err_to_q;
   assign sys_id       = sys_id_q;
   assign sys_ts       = sys_ts_q;
   assign retries_used = ret_q;

endmodule

// File: tb/tb_nios_base_sysid_checker.sv
// Bench for nios_base_sysid_checker: three configurations, each
// with its own sysid slave model; scenario tasks run in sequence.
module tb_nios_base_sysid_checker;

   localparam logic [31:0] EID  = 32'd953745243;
   localparam logic [31:0] ETS  = 32'd1314387359;
   localparam logic [31:0] GARB = 32'hDEAD_BEEF;
   localparam int FOREVER = 1000;

   logic        clk;
   logic        rst_n   [3];
   logic        recheck [3];
   logic        m_read  [3];
   logic        m_addr  [3];
   logic        m_wait  [3];
   logic [31:0] m_rdata [3];
   logic        done    [3];
   logic        pass    [3];
   logic        err_id  [3];
   logic        err_ts  [3];
   logic        err_to  [3];
   logic [31:0] sys_id  [3];
   logic [31:0] sys_ts  [3];
   logic [2:0]  ret     [3];

   logic [31:0] d0 [3];
   logic [31:0] d1 [3];
   int          s0 [3];
   int          s1 [3];

   int       nread [3] = '{0, 0, 0};
   int       rdcyc [3] = '{0, 0, 0};
   int       stab  [3] = '{0, 0, 0};
   logic [7:0] ahist [3] = '{default: '0};

   int total = 0;
   int bad   = 0;

   function automatic int lat_of(input int g);
      return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
   endfunction

   // Cycles from the starting edge (recheck, or IDLE exit) to done.
   function automatic int seq_cycles(input int g, input int a, input int b);
      return (a + 1 + lat_of(g)) + (b + 1 + lat_of(g)) + 1;
   endfunction

   function automatic logic [73:0] outs(input int g);
      return {m_read[g], m_addr[g], done[g], pass[g], err_id[g],
              err_ts[g], err_to[g], ret[g], sys_id[g], sys_ts[g]};
   endfunction

   function automatic logic [31:0] rand_not(input logic [31:0] x);
      logic [31:0] v;
      v = $urandom;
      if (v == x || v == GARB) v = x ^ 32'h0000_0100;
      return v;
   endfunction

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : gi
         localparam int L = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
         localparam int T = (g == 0) ? 255 : ((g == 1) ? 16 : 8);
         localparam int R = (g == 2) ? 2 : 3;
         localparam bit A = (g == 2) ? 1'b0 : 1'b1;
         localparam int LI = (L > 0) ? L - 1 : 0;

         nios_base_sysid_checker #(
            .EXPECTED_ID    (EID),
            .EXPECTED_TS    (ETS),
            .READ_LATENCY   (L),
            .TIMEOUT_CYCLES (T),
            .MAX_RETRIES    (R),
            .AUTO_START     (A)
         ) dut (
            .clock         (clk),
            .reset_n       (rst_n[g]),
            .m_address     (m_addr[g]),
            .m_read        (m_read[g]),
            .m_waitrequest (m_wait[g]),
            .m_readdata    (m_rdata[g]),
            .recheck       (recheck[g]),
            .done          (done[g]),
            .pass          (pass[g]),
            .err_id        (err_id[g]),
            .err_ts        (err_ts[g]),
            .err_timeout   (err_to[g]),
            .sys_id        (sys_id[g]),
            .sys_ts        (sys_ts[g]),
            .retries_used  (ret[g])
         );

         logic [7:0]  scnt;
         logic [3:0]  pv;
         logic [31:0] pd [4];
         logic        pst, pa;
         int          st;
         logic [31:0] rd;

         always_comb st = m_addr[g] ? s1[g] : s0[g];

         assign m_wait[g] = m_read[g] && (int'(scnt) < st);

         // Data is valid only on the exact latency cycle; garbage otherwise.
         always_comb begin
            rd = GARB;
            if (L == 0) begin
               if (m_read[g] && !m_wait[g])
                  rd = m_addr[g] ? d1[g] : d0[g];
            end else if (pv[LI]) begin
               rd = pd[LI];
            end
         end

         assign m_rdata[g] = rd;

         always @(posedge clk) begin
            if (!rst_n[g]) begin
               scnt <= '0;
               pv   <= '0;
               pst  <= 1'b0;
               pa   <= 1'b0;
            end else begin
               if (m_read[g] && m_wait[g]) begin
                  if (scnt != 8'hFF) scnt <= scnt + 1'b1;
               end else begin
                  scnt <= '0;
               end
               pv    <= {pv[2:0], m_read[g] && !m_wait[g]};
               pd[0] <= m_addr[g] ? d1[g] : d0[g];
               for (int k = 1; k < 4; k++) pd[k] <= pd[k-1];
               if (pst && (!m_read[g] || m_addr[g] != pa))
                  stab[g] <= stab[g] + 1;
               pst <= m_read[g] && m_wait[g];
               pa  <= m_addr[g];
            end
            if (m_read[g]) rdcyc[g] <= rdcyc[g] + 1;
            if (m_read[g] && !m_wait[g]) begin
               nread[g] <= nread[g] + 1;
               ahist[g] <= {ahist[g][6:0], m_addr[g]};
            end
         end
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset(input int g);
      rst_n[g] = 1'b0;
      tick();
      tick();
   endtask

   task automatic pulse(input int g);
      recheck[g] = 1'b1;
      tick();
      recheck[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int budget, output int cyc);
      cyc = 0;
      while (!done[g] && cyc < budget) begin
         tick();
         cyc++;
      end
      if (!done[g]) begin
         total++;
         bad++;
         $display("FAIL wait_done inst=%0d: done=%0b after %0d cycles, want 1",
                  g, done[g], cyc);
      end
   endtask

   task automatic test_reset();
      recheck[2] = 1'b1;
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
      tick();
      tick();
      tick();
      recheck[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (outs(i) !== 74'd0) begin
            bad++;
            $display("FAIL reset inst=%0d: got %h want 0", i, outs(i));
         end
      end
   endtask

   task automatic test_pass_basic();
      int cyc, b_rc;
      d0[0] = EID; d1[0] = ETS; s0[0] = 0; s1[0] = 0;
      hold_reset(0);
      b_rc = rdcyc[0];
      rst_n[0] = 1'b1;
      wait_done(0, 50, cyc);
      total++;
      if (cyc !== seq_cycles(0, 0, 0) + 1) begin
         bad++;
         $display("FAIL basic_latency: got %0d want %0d", cyc, seq_cycles(0, 0, 0) + 1);
      end
      total++;
      if (pass[0] !== 1'b1) begin
         bad++;
         $display("FAIL basic_pass: got %b want 1", pass[0]);
      end
      tick();
      total++;
      if (rdcyc[0] - b_rc !== 2 || ahist[0][1:0] !== 2'b01 || m_read[0] !== 1'b0) begin
         bad++;
         $display("FAIL basic_reads: cycles=%0d addrs=%b m_read=%b want 2/01/0",
                  rdcyc[0] - b_rc, ahist[0][1:0], m_read[0]);
      end
      total++;
      if (sys_id[0] !== EID || sys_ts[0] !== ETS) begin
         bad++;
         $display("FAIL basic_data: got %h/%h want %h/%h", sys_id[0], sys_ts[0], EID, ETS);
      end
   endtask

   task automatic test_bad_ts();
      int cyc;
      d0[0] = EID; d1[0] = 32'h0;
      hold_reset(0);
      rst_n[0] = 1'b1;
      wait_done(0, 50, cyc);
      total++;
      if ({done[0], pass[0], err_id[0], err_ts[0], err_to[0]} !== 5'b10010) begin
         bad++;
         $display("FAIL bad_ts_flags: got %b want 10010",
                  {done[0], pass[0], err_id[0], err_ts[0], err_to[0]});
      end
      total++;
      if (sys_ts[0] !== 32'h0 || sys_id[0] !== EID) begin
         bad++;
         $display("FAIL bad_ts_data: got %h/%h want %h/0", sys_id[0], sys_ts[0], EID);
      end
   endtask

   task automatic test_timeout();
      int cyc, b_rc;
      d0[2] = EID; d1[2] = ETS; s0[2] = FOREVER; s1[2] = 0;
      hold_reset(2);
      b_rc = rdcyc[2];
      rst_n[2] = 1'b1;
      tick(); tick(); tick();
      total++;
      if (m_read[2] !== 1'b0 || rdcyc[2] !== b_rc) begin
         bad++;
         $display("FAIL no_autostart: m_read=%b cycles=%0d want 0/0", m_read[2], rdcyc[2] - b_rc);
      end
      pulse(2);
      wait_done(2, 200, cyc);
      total++;
      if (cyc !== 3 * 8) begin
         bad++;
         $display("FAIL timeout_cycles: got %0d want %0d", cyc, 3 * 8);
      end
      total++;
      if ({done[2], pass[2], err_to[2], err_id[2], err_ts[2]} !== 5'b10100 || ret[2] !== 3'd2) begin
         bad++;
         $display("FAIL timeout_flags: got %b ret=%0d want 10100 ret=2",
                  {done[2], pass[2], err_to[2], err_id[2], err_ts[2]}, ret[2]);
      end
      total++;
      if (m_read[2] !== 1'b0 || rdcyc[2] - b_rc !== 24 || sys_id[2] !== 32'h0) begin
         bad++;
         $display("FAIL timeout_bus: m_read=%b rdcyc=%0d sys_id=%h want 0/24/0",
                  m_read[2], rdcyc[2] - b_rc, sys_id[2]);
      end
   endtask

   task automatic test_latency();
      int cyc, b_st;
      d0[1] = EID; d1[1] = ETS; s0[1] = 3; s1[1] = 0;
      hold_reset(1);
      b_st = stab[1];
      rst_n[1] = 1'b1;
      wait_done(1, 60, cyc);
      total++;
      if (cyc !== seq_cycles(1, 3, 0) + 1) begin
         bad++;
         $display("FAIL lat_cycles: got %0d want %0d", cyc, seq_cycles(1, 3, 0) + 1);
      end
      total++;
      if (pass[1] !== 1'b1 || sys_id[1] !== EID || sys_ts[1] !== ETS || stab[1] !== b_st) begin
         bad++;
         $display("FAIL lat_result: pass=%b id=%h ts=%h unstable=%0d want 1/%h/%h/0",
                  pass[1], sys_id[1], sys_ts[1], stab[1] - b_st, EID, ETS);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      d0[1] = EID; d1[1] = ETS; s0[1] = 0; s1[1] = 0;
      hold_reset(1);
      rst_n[1] = 1'b1;
      for (int i = 0; i < 1 + (0 + 1 + lat_of(1)) + 1; i++) tick();
      total++;
      if (m_read[1] !== 1'b0 || sys_id[1] !== EID || done[1] !== 1'b0) begin
         bad++;
         $display("FAIL mid_state: m_read=%b id=%h done=%b want 0/%h/0",
                  m_read[1], sys_id[1], done[1], EID);
      end
      rst_n[1] = 1'b0;
      tick();
      total++;
      if (outs(1) !== 74'd0) begin
         bad++;
         $display("FAIL mid_reset: got %h want 0", outs(1));
      end
      rst_n[1] = 1'b1;
      wait_done(1, 60, cyc);
      total++;
      if (cyc !== seq_cycles(1, 0, 0) + 1 || pass[1] !== 1'b1) begin
         bad++;
         $display("FAIL mid_rerun: cycles=%0d pass=%b want %0d/1",
                  cyc, pass[1], seq_cycles(1, 0, 0) + 1);
      end
   endtask

   task automatic test_recheck();
      int cyc, b_rc, b_nr, n;
      logic [31:0] wrong;
      wrong = ETS ^ 32'h1;
      d0[2] = EID; d1[2] = wrong; s0[2] = 0; s1[2] = 4;
      hold_reset(2);
      b_rc = rdcyc[2];
      b_nr = nread[2];
      rst_n[2] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (rdcyc[2] !== b_rc || done[2] !== 1'b0) begin
         bad++;
         $display("FAIL idle_wait: rdcyc=%0d done=%b want 0/0", rdcyc[2] - b_rc, done[2]);
      end
      pulse(2);
      n = 0;
      while (!(m_read[2] && m_addr[2]) && n < 20) begin
         tick();
         n++;
      end
      pulse(2);
      total++;
      if (m_read[2] !== 1'b1 || m_addr[2] !== 1'b1) begin
         bad++;
         $display("FAIL recheck_ignored: m_read=%b addr=%b want 1/1", m_read[2], m_addr[2]);
      end
      wait_done(2, 60, cyc);
      total++;
      if ({done[2], pass[2], err_id[2], err_ts[2], err_to[2]} !== 5'b10010 ||
          nread[2] - b_nr !== 2 || sys_ts[2] !== wrong) begin
         bad++;
         $display("FAIL recheck_first: flags=%b reads=%0d ts=%h want 10010/2/%h",
                  {done[2], pass[2], err_id[2], err_ts[2], err_to[2]},
                  nread[2] - b_nr, sys_ts[2], wrong);
      end
      d1[2] = ETS; s1[2] = 0;
      pulse(2);
      total++;
      if ({done[2], pass[2], err_ts[2]} !== 3'b000 || sys_ts[2] !== wrong) begin
         bad++;
         $display("FAIL recheck_clear: flags=%b ts=%h want 000/%h",
                  {done[2], pass[2], err_ts[2]}, sys_ts[2], wrong);
      end
      wait_done(2, 60, cyc);
      total++;
      if (cyc !== seq_cycles(2, 0, 0) || pass[2] !== 1'b1 ||
          sys_ts[2] !== ETS || nread[2] - b_nr !== 4) begin
         bad++;
         $display("FAIL recheck_rerun: cycles=%0d pass=%b ts=%h reads=%0d want %0d/1/%h/4",
                  cyc, pass[2], sys_ts[2], nread[2] - b_nr, seq_cycles(2, 0, 0), ETS);
      end
   endtask

   task automatic test_random();
      int cyc, gg, b_st;
      logic exp_p, exp_ei, exp_et;
      for (int it = 0; it < 12; it++) begin
         gg = it % 3;
         d0[gg] = $urandom_range(0, 1) ? EID : rand_not(EID);
         d1[gg] = $urandom_range(0, 1) ? ETS : rand_not(ETS);
         s0[gg] = $urandom_range(0, 3);
         s1[gg] = $urandom_range(0, 3);
         exp_ei = (d0[gg] != EID);
         exp_et = (d1[gg] != ETS);
         exp_p  = !exp_ei && !exp_et;
         b_st = stab[gg];
         pulse(gg);
         wait_done(gg, 100, cyc);
         total++;
         if (cyc !== seq_cycles(gg, s0[gg], s1[gg])) begin
            bad++;
            $display("FAIL rand_cycles it=%0d: got %0d want %0d",
                     it, cyc, seq_cycles(gg, s0[gg], s1[gg]));
         end
         total++;
         if ({pass[gg], err_id[gg], err_ts[gg], err_to[gg], ret[gg]} !==
             {exp_p, exp_ei, exp_et, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL rand_flags it=%0d: got %b want %b", it,
                     {pass[gg], err_id[gg], err_ts[gg], err_to[gg], ret[gg]},
                     {exp_p, exp_ei, exp_et, 1'b0, 3'd0});
         end
         total++;
         if (sys_id[gg] !== d0[gg] || sys_ts[gg] !== d1[gg] || stab[gg] !== b_st) begin
            bad++;
            $display("FAIL rand_data it=%0d: got %h/%h unstable=%0d want %h/%h/0",
                     it, sys_id[gg], sys_ts[gg], stab[gg] - b_st, d0[gg], d1[gg]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0;
         recheck[i] = 1'b0;
         d0[i] = EID;
         d1[i] = ETS;
         s0[i] = 0;
         s1[i] = 0;
      end
      test_reset();
      test_pass_basic();
      test_bad_ts();
      test_timeout();
      test_latency();
      test_reset_mid();
      test_recheck();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
